// File: rtl/hazard_scoreboard_pkg.sv
// Shared hazard-scoreboard constants and the CNT_WIDTH vs WB_LATENCY legality check.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package hazard_scoreboard_pkg;

  localparam int HZ_WB_LATENCY_DEFAULT = 8;
  localparam int HZ_CNT_WIDTH          = 4;

  // Latency must be 1..15 and loadable into the counter without truncation.
  function automatic bit hz_cnt_width_ok(input int cnt_width, input int wb_latency);
    return (wb_latency >= 1) && (wb_latency <= 15) && (wb_latency < (1 << cnt_width));
  endfunction

endpackage

// File: rtl/hz_reg_counter.sv
// One register's pending-write down-counter: load wins over decrement, never underflows.
module hz_reg_counter #(
  parameter int CNT_WIDTH = 4,
  parameter int LOAD_VAL  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic nonzero,
  output logic nonzero_next
);

  localparam logic [CNT_WIDTH-1:0] LOAD_CNT = CNT_WIDTH'(LOAD_VAL);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (load)
      cnt_next = LOAD_CNT;
    else if (cnt != '0)
      cnt_next = cnt - CNT_WIDTH'(1);
  end

  assign nonzero_next = (cnt_next != '0);

  // The flag is its own flop so the stall muxes and pending_o see a glitch-free bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      nonzero <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      nonzero <= nonzero_next;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage RAW interlock: stalls decode while any used source has a write in flight.
// Define HAZARD_STATS_EN to build the saturating stall-cycle counter; otherwise stall_cycles_o is 0.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int WB_LATENCY     = HZ_WB_LATENCY_DEFAULT,
  parameter int CNT_WIDTH      = HZ_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] ra_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rb_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rc_addr_i,
  input  logic                      ra_used_i,
  input  logic                      rb_used_i,
  input  logic                      rc_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      regwrite_i,
  output logic                      stall_o,
  output logic                      issue_o,
  output logic [NUM_REGS-1:0]       pending_o,
  output logic                      busy_o,
  output logic [31:0]               stall_cycles_o
);

  if (!hz_cnt_width_ok(CNT_WIDTH, WB_LATENCY)) begin : g_cfg_err
    $error("hazard_scoreboard: CNT_WIDTH too small or WB_LATENCY out of 1..15");
  end

  logic [NUM_REGS-1:0] nz;
  logic [NUM_REGS-1:0] nz_next;
  logic [NUM_REGS-1:0] load;
  logic                haz;

  // Sources compare against the pre-edge counters, so self-dependence sees the old value.
  assign haz = (ra_used_i & nz[ra_addr_i]) |
               (rb_used_i & nz[rb_addr_i]) |
               (rc_used_i & nz[rc_addr_i]);

  assign stall_o = issue_valid_i & haz;
  assign issue_o = issue_valid_i & ~haz;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign load[r] = issue_o & regwrite_i & (rd_addr_i == REG_ADDR_WIDTH'(r));

    hz_reg_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .LOAD_VAL  (WB_LATENCY)
    ) u_cnt (
      .clk          (clk),
      .rst          (rst),
      .load         (load[r]),
      .nonzero      (nz[r]),
      .nonzero_next (nz_next[r])
    );
  end

  assign pending_o = nz;

  always_ff @(posedge clk) begin
    if (rst)
      busy_o <= 1'b0;
    else
      busy_o <= |nz_next;
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_o && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cycles_o = stall_cnt;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a ready-time model predicts each cycle's outputs.
module tb_hazard_scoreboard;

  localparam int WB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  ra_addr = '0, rb_addr = '0, rc_addr = '0, rd_addr = '0;
  logic        ra_used = 1'b0, rb_used = 1'b0, rc_used = 1'b0;
  logic        regwrite = 1'b0;
  logic        stall, issue, busy;
  logic [31:0] pending, stall_cycles;

  hazard_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid),
    .ra_addr_i      (ra_addr),
    .rb_addr_i      (rb_addr),
    .rc_addr_i      (rc_addr),
    .ra_used_i      (ra_used),
    .rb_used_i      (rb_used),
    .rc_used_i      (rc_used),
    .rd_addr_i      (rd_addr),
    .regwrite_i     (regwrite),
    .stall_o        (stall),
    .issue_o        (issue),
    .pending_o      (pending),
    .busy_o         (busy),
    .stall_cycles_o (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        issue;
    logic [31:0] pending;
    logic        busy;
    logic [31:0] stats;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   ready[32];
  int   stats_model = 0;
  int   obs_stalls = 0;
  bit   last_issue = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (stall === 1'b1) obs_stalls++;
      chk("stall",        32'(stall), 32'(e.stall));
      chk("issue",        32'(issue), 32'(e.issue));
      chk("pending",      pending,    e.pending);
      chk("busy",         32'(busy),  32'(e.busy));
      chk("stall_cycles", stall_cycles, e.stats);
    end
  end

  // Model: a register is pending in cycle c while c < ready[r] (issue cycle + WB + 1).
  task automatic drv(input bit v, input int ra, input bit rau, input int rb, input bit rbu,
                     input int rc, input bit rcu, input int rd, input bit wr, input bit r);
    exp_t        e;
    bit          haz;
    logic [31:0] pend;
    @(negedge clk);
    issue_valid = v;
    ra_addr = 5'(ra); rb_addr = 5'(rb); rc_addr = 5'(rc); rd_addr = 5'(rd);
    ra_used = rau; rb_used = rbu; rc_used = rcu;
    regwrite = wr; rst = r;
    haz = (rau && ready[ra] > cyc) || (rbu && ready[rb] > cyc) || (rcu && ready[rc] > cyc);
    pend = '0;
    for (int i = 0; i < 32; i++) pend[i] = (ready[i] > cyc);
    e.stall   = v && haz;
    e.issue   = v && !haz;
    e.pending = pend;
    e.busy    = |pend;
`ifdef HAZARD_STATS_EN
    e.stats   = 32'(stats_model);
`else
    e.stats   = '0;
`endif
    sb.push_back(e);
    last_issue = e.issue;
    if (r) begin
      for (int i = 0; i < 32; i++) ready[i] = 0;
      stats_model = 0;
    end else begin
      if (e.stall) stats_model++;
      if (e.issue && wr) ready[rd] = cyc + WB + 1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Holds an instruction until it issues; checks the DUT's observed stall run length.
  task automatic present(input int ra, input bit rau, input int rb, input bit rbu,
                         input int rc, input bit rcu, input int rd, input bit wr,
                         input int exp_stalls);
    int n;
    int s0;
    n  = 0;
    s0 = obs_stalls;
    drv(1'b1, ra, rau, rb, rbu, rc, rcu, rd, wr, 1'b0);
    while (!last_issue && n < 20) begin
      n++;
      drv(1'b1, ra, rau, rb, rbu, rc, rcu, rd, wr, 1'b0);
    end
    if (!last_issue) chk("issue_timeout", 32'd0, 32'd1);
    #3;
    chk("stall_run", 32'(obs_stalls - s0), 32'(exp_stalls));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ready[i] = 0;
    repeat (2) @(posedge clk);
    drv(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    drv(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    idle(2);

    // Producer R5, dependent reads R5 on rb
    present(0, 1'b0, 0, 1'b0, 0, 1'b0, 5, 1'b1, 0);
    present(0, 1'b0, 5, 1'b1, 0, 1'b0, 0, 1'b0, WB);

    // Address matches but source unused: no stall
    present(0, 1'b0, 0, 1'b0, 0, 1'b0, 3, 1'b1, 0);
    present(3, 1'b0, 0, 1'b0, 0, 1'b0, 10, 1'b0, 0);
    idle(9);

    // Invalid instruction never stalls even with a pending source
    present(0, 1'b0, 0, 1'b0, 0, 1'b0, 4, 1'b1, 0);
    drv(1'b0, 4, 1'b1, 4, 1'b1, 4, 1'b1, 0, 1'b0, 1'b0);
    idle(8);

    // WAW reload of R7
    present(0, 1'b0, 0, 1'b0, 0, 1'b0, 7, 1'b1, 0);
    idle(2);
    present(0, 1'b0, 0, 1'b0, 0, 1'b0, 7, 1'b1, 0);
    present(7, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, WB);

    // Independent back-to-back stream R1..R8
    for (int i = 1; i <= 8; i++) present(20, 1'b1, 0, 1'b0, 0, 1'b0, i, 1'b1, 0);
    idle(10);

    // Self-dependence, then a consumer on rc
    present(9, 1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 0);
    present(0, 1'b0, 0, 1'b0, 9, 1'b1, 0, 1'b0, WB);

    // Reset mid-flight clears R2
    present(0, 1'b0, 0, 1'b0, 0, 1'b0, 2, 1'b1, 0);
    idle(2);
    drv(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    present(2, 1'b1, 2, 1'b1, 0, 1'b0, 0, 1'b0, 0);
    idle(3);

    #5;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
